rem_seq: RTL and testbench

Sequential sign-magnitude divider that produces the remainder, quotient and a divide-by-zero flag using a start/done handshake. It is the clocked, multi-cycle counterpart of the combinational `rem` unit and uses the same operand and flag semantics. It computes one quotient bit per cycle by restoring division, and its results can be checked bit-for-bit against the `rem` bench model.

---
 rtl/rem_seq.sv | 104 ++++++++++
 tb/tb_rem_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/rem_seq.sv
// Sequential sign-magnitude divider: restoring division, one quotient bit per
// cycle, start/done handshake with registered remainder, quotient and divbyzero.
module rem_seq #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] numerator,
  input  logic [WIDTH-1:0] denominator,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] remainder,
  output logic [WIDTH-1:0] quotient,
  output logic             divbyzero
);

  localparam int M  = WIDTH - 1;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic            nsign;
  logic            dsign;
  logic [M-1:0]    dmag;
  logic [M-1:0]    prem;
  logic [M-1:0]    sreg;
  logic [CW-1:0]   count;

  logic [M:0]      shifted;
  logic            ge;
  logic [M-1:0]    prem_next;
  logic [M-1:0]    sreg_next;

  // One restoring step: bring in the next dividend bit, trial-subtract |d|,
  // and shift the resulting quotient bit into the freed LSB of the shift register.
  always_comb begin
    shifted   = {prem, sreg[M-1]};
    ge        = (shifted >= {1'b0, dmag});
    prem_next = ge ? M'(shifted - {1'b0, dmag}) : shifted[M-1:0];
    sreg_next = (sreg << 1) | M'(ge);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      remainder <= '0;
      quotient  <= '0;
      divbyzero <= 1'b0;
      nsign     <= 1'b0;
      dsign     <= 1'b0;
      dmag      <= '0;
      prem      <= '0;
      sreg      <= '0;
      count     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            nsign <= numerator[WIDTH-1];
            dsign <= denominator[WIDTH-1];
            dmag  <= denominator[M-1:0];
            busy  <= 1'b1;
            if (denominator[M-1:0] == '0) begin
              // Divide-by-zero passes the numerator through untouched, sign included.
              remainder <= numerator;
              quotient  <= '0;
              divbyzero <= 1'b1;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              prem  <= '0;
              sreg  <= numerator[M-1:0];
              count <= CW'(M);
              state <= CALC;
            end
          end
        end
        CALC: begin
          prem  <= prem_next;
          sreg  <= sreg_next;
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            remainder <= {nsign & (|prem_next), prem_next};
            quotient  <= {(nsign ^ dsign) & (|sreg_next), sreg_next};
            divbyzero <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rem_seq.sv
// Self-checking bench for rem_seq: directed table, exhaustive and random
// operands against an arithmetic reference model, plus handshake and reset sequences.
module tb_rem_seq;

  localparam int W = 3;
  localparam int M = W - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] numerator = '0;
  logic [W-1:0] denominator = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] remainder;
  logic [W-1:0] quotient;
  logic         divbyzero;

  int checks = 0;
  int failures = 0;

  rem_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .numerator(numerator), .denominator(denominator),
    .busy(busy), .done(done), .remainder(remainder),
    .quotient(quotient), .divbyzero(divbyzero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] n;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] q;
    logic         z;
  } vec_t;

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model from the arithmetic rules, not from the datapath steps.
  task automatic model(input logic [W-1:0] n, input logic [W-1:0] d,
                       output logic [W-1:0] r, output logic [W-1:0] q, output logic z);
    int nm, dm, rm, qm;
    nm = int'(n[M-1:0]);
    dm = int'(d[M-1:0]);
    if (dm == 0) begin
      r = n; q = '0; z = 1'b1;
    end else begin
      rm = nm % dm;
      qm = nm / dm;
      r = {n[W-1] && (rm != 0), M'(rm)};
      q = {(n[W-1] ^ d[W-1]) && (qm != 0), M'(qm)};
      z = 1'b0;
    end
  endtask

  // Issue one operation from IDLE, scramble the operand inputs after accept,
  // and check latency, busy/done shape and the results.
  task automatic applyStimulus(input string tag, input logic [W-1:0] n, input logic [W-1:0] d,
                               input logic [W-1:0] er, input logic [W-1:0] eq, input logic ez);
    int lat;
    @(negedge clk);
    checkOutput({tag, " idle busy"}, int'(busy), 0);
    start = 1'b1; numerator = n; denominator = d;
    @(negedge clk);
    start = 1'b0;
    numerator = W'($urandom); denominator = W'($urandom);
    checkOutput({tag, " busy after accept"}, int'(busy), 1);
    lat = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, " latency"}, lat, ez ? 0 : M);
    checkOutput({tag, " remainder"}, int'(remainder), int'(er));
    checkOutput({tag, " quotient"}, int'(quotient), int'(eq));
    checkOutput({tag, " divbyzero"}, int'(divbyzero), int'(ez));
    checkOutput({tag, " busy in done"}, int'(busy), 1);
    @(negedge clk);
    checkOutput({tag, " done pulse width"}, int'(done), 0);
    checkOutput({tag, " busy cleared"}, int'(busy), 0);
    checkOutput({tag, " result hold"}, int'(remainder), int'(er));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t table_v[6];
    logic [W-1:0] er, eq, n, d;
    logic ez;
    int doneCyc[$];
    int cyc;

    table_v[0] = '{3'b011, 3'b010, 3'b001, 3'b001, 1'b0};
    table_v[1] = '{3'b111, 3'b010, 3'b101, 3'b101, 1'b0};
    table_v[2] = '{3'b110, 3'b101, 3'b000, 3'b010, 1'b0};
    table_v[3] = '{3'b101, 3'b100, 3'b101, 3'b000, 1'b1};
    table_v[4] = '{3'b010, 3'b000, 3'b010, 3'b000, 1'b1};
    table_v[5] = '{3'b011, 3'b011, 3'b000, 3'b001, 1'b0};

    // Reset state
    @(negedge clk);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    checkOutput("reset remainder", int'(remainder), 0);
    checkOutput("reset quotient", int'(quotient), 0);
    checkOutput("reset divbyzero", int'(divbyzero), 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++)
      applyStimulus($sformatf("table%0d", i), table_v[i].n, table_v[i].d,
                    table_v[i].r, table_v[i].q, table_v[i].z);

    for (int i = 0; i < 64; i++) begin
      n = W'(i >> 3); d = W'(i & 7);
      model(n, d, er, eq, ez);
      applyStimulus($sformatf("exh n=%0d d=%0d", n, d), n, d, er, eq, ez);
    end

    for (int i = 0; i < 30; i++) begin
      n = W'($urandom); d = W'($urandom);
      model(n, d, er, eq, ez);
      applyStimulus($sformatf("rand n=%0d d=%0d", n, d), n, d, er, eq, ez);
    end

    // start held high: done pulses spaced M+2 apart (2 for divide-by-zero)
    for (int k = 0; k < 2; k++) begin
      doneCyc.delete();
      @(negedge clk);
      start = 1'b1; numerator = 3'b011; denominator = (k == 0) ? 3'b010 : 3'b000;
      for (cyc = 0; cyc < 14; cyc++) begin
        @(negedge clk);
        if (done) doneCyc.push_back(cyc);
      end
      start = 1'b0;
      checkOutput($sformatf("held start done count k=%0d", k), doneCyc.size() >= 3 ? 1 : 0, 1);
      if (doneCyc.size() >= 3) begin
        checkOutput($sformatf("held start spacing1 k=%0d", k), doneCyc[1] - doneCyc[0], (k == 0) ? M + 2 : 2);
        checkOutput($sformatf("held start spacing2 k=%0d", k), doneCyc[2] - doneCyc[1], (k == 0) ? M + 2 : 2);
      end
      repeat (4) @(negedge clk);
    end

    // start pulsed in CALC and DONE, operands changed mid-CALC: ignored
    @(negedge clk);
    start = 1'b1; numerator = 3'b011; denominator = 3'b001;
    @(negedge clk);
    numerator = 3'b010; denominator = 3'b011;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    checkOutput("ignore done", int'(done), 1);
    checkOutput("ignore remainder", int'(remainder), 0);
    checkOutput("ignore quotient", int'(quotient), 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    checkOutput("start in done ignored", cyc, 0);

    // Asynchronous reset mid-CALC
    @(negedge clk);
    start = 1'b1; numerator = 3'b011; denominator = 3'b010;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("async reset busy", int'(busy), 0);
    checkOutput("async reset done", int'(done), 0);
    checkOutput("async reset remainder", int'(remainder), 0);
    checkOutput("async reset quotient", int'(quotient), 0);
    checkOutput("async reset divbyzero", int'(divbyzero), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) cyc++;
    end
    checkOutput("no stale done after reset", cyc, 0);
    applyStimulus("post reset", 3'b011, 3'b011, 3'b000, 3'b001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
